// File: rtl/prbs_pattern_source_if.sv
// prbs_pattern_source_if: control and byte-stream bundle
// for the preamble + PRBS-15 pattern source.
interface prbs_pattern_source_if #(
    parameter int BusWidth = 8
);
    logic                Start;
    logic                Stop;
    logic                Enable;
    logic [BusWidth-1:0] OutData;
    logic                OutValid;
    logic                PatternDone;

    modport master (
        output Start,
        output Stop,
        output Enable,
        input  OutData,
        input  OutValid,
        input  PatternDone
    );

    modport slave (
        input  Start,
        input  Stop,
        input  Enable,
        output OutData,
        output OutValid,
        output PatternDone
    );
endinterface

// File: rtl/prbs_pattern_source.sv
// prbs_pattern_source: emits a repeated 32-bit preamble,
// then an endless PRBS-15 (x^15+x^14+1) byte stream.
module prbs_pattern_source #(
    parameter int                  BusWidth  = 8,
    parameter int                  NumWidth  = 4,
    parameter logic [31:0]         InPattern = 32'haabbccdd,
    parameter logic [NumWidth-1:0] nPattern  = 4'd4,
    parameter logic [14:0]         Seed      = 15'h7fff
) (
    input  logic                  CLK,
    input  logic                  RST,
    prbs_pattern_source_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PAT,
        S_PRBS
    } state_t;

    // An all-zero LFSR would lock up, so a zero seed
    // is replaced by 1 when a transmission starts.
    localparam logic [14:0] LoadSeed =
        (Seed == 15'd0) ? 15'h0001 : Seed;

    localparam logic [NumWidth-1:0] LastRep =
        nPattern - 1'b1;

    state_t                r_state;
    logic [1:0]            r_idx;
    logic [NumWidth-1:0]   r_rep;
    logic [14:0]           r_lfsr;
    logic [BusWidth-1:0]   r_data;
    logic                  r_valid;
    logic                  r_done;

    state_t                w_state;
    logic [1:0]            w_idx;
    logic [NumWidth-1:0]   w_rep;
    logic [14:0]           w_lfsr;
    logic [BusWidth-1:0]   w_data;
    logic                  w_valid;
    logic                  w_done;

    logic [7:0]            w_pat_byte;
    logic [7:0]            w_prbs_byte;
    logic [14:0]           w_prbs_lfsr;
    logic                  w_new_bit;

    // Select the preamble byte, least significant first.
    always_comb begin
        w_pat_byte = InPattern[7:0];
        unique case (r_idx)
            2'd0: w_pat_byte = InPattern[7:0];
            2'd1: w_pat_byte = InPattern[15:8];
            2'd2: w_pat_byte = InPattern[23:16];
            2'd3: w_pat_byte = InPattern[31:24];
            default: w_pat_byte = InPattern[7:0];
        endcase
    end

    // Eight LFSR steps per byte; bit k lands in byte[k].
    always_comb begin
        w_prbs_lfsr = r_lfsr;
        w_prbs_byte = 8'h00;
        w_new_bit   = 1'b0;
        for (int k = 0; k < 8; k++) begin
            w_new_bit      = w_prbs_lfsr[14] ^ w_prbs_lfsr[13];
            w_prbs_lfsr    = {w_prbs_lfsr[13:0], w_new_bit};
            w_prbs_byte[k] = w_new_bit;
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        w_state = r_state;
        w_idx   = r_idx;
        w_rep   = r_rep;
        w_lfsr  = r_lfsr;
        w_data  = r_data;
        w_valid = r_valid;
        w_done  = r_done;
        if (bus.Stop) begin
            w_state = S_IDLE;
            w_idx   = 2'd0;
            w_rep   = '0;
            w_data  = '0;
            w_valid = 1'b0;
            w_done  = 1'b0;
        end else if (bus.Enable) begin
            unique case (r_state)
                S_IDLE: begin
                    w_data  = '0;
                    w_valid = 1'b0;
                    w_done  = 1'b0;
                    if (bus.Start) begin
                        w_state = S_PAT;
                        w_idx   = 2'd0;
                        w_rep   = '0;
                        w_lfsr  = LoadSeed;
                    end
                end
                S_PAT: begin
                    w_data  = BusWidth'(w_pat_byte);
                    w_valid = 1'b1;
                    w_done  = 1'b0;
                    if (r_idx == 2'd3) begin
                        w_idx = 2'd0;
                        if (r_rep == LastRep) begin
                            w_state = S_PRBS;
                        end else begin
                            w_rep = r_rep + 1'b1;
                        end
                    end else begin
                        w_idx = r_idx + 2'd1;
                    end
                end
                S_PRBS: begin
                    w_data  = BusWidth'(w_prbs_byte);
                    w_valid = 1'b1;
                    w_done  = 1'b1;
                    w_lfsr  = w_prbs_lfsr;
                end
                default: begin
                    w_state = S_IDLE;
                    w_data  = '0;
                    w_valid = 1'b0;
                    w_done  = 1'b0;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_idx   <= 2'd0;
            r_rep   <= '0;
            r_lfsr  <= Seed;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_idx   <= w_idx;
            r_rep   <= w_rep;
            r_lfsr  <= w_lfsr;
            r_data  <= w_data;
            r_valid <= w_valid;
            r_done  <= w_done;
        end
    end

    assign bus.OutData     = r_data;
    assign bus.OutValid    = r_valid;
    assign bus.PatternDone = r_done;

endmodule

// File: tb/tb_prbs_pattern_source.sv
// tb_prbs_pattern_source: directed checks of preamble,
// PRBS stream, enable/stop/reset behaviour.
module tb_prbs_pattern_source;

    logic CLK = 1'b0;
    logic RST;
    int   checks = 0;
    int   errors = 0;

    always #5 CLK = ~CLK;

    prbs_pattern_source_if #(.BusWidth(8)) b1 ();
    prbs_pattern_source_if #(.BusWidth(8)) b2 ();

    prbs_pattern_source u_dut1 (
        .CLK (CLK),
        .RST (RST),
        .bus (b1.slave)
    );

    prbs_pattern_source #(
        .nPattern (4'd1),
        .Seed     (15'h0001)
    ) u_dut2 (
        .CLK (CLK),
        .RST (RST),
        .bus (b2.slave)
    );

    // Bit sequence of the PRBS for seed 15'h0001.
    // seq[0..14] holds the seed, oldest bit first;
    // each new bit is s[n-15] ^ s[n-14].
    bit seq [0:8047];

    task automatic chk(
        input string       tag,
        input logic [31:0] obs,
        input logic [31:0] exp
    );
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h",
                     tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic out1(
        input string      tag,
        input logic [7:0] d,
        input logic       v,
        input logic       p
    );
        chk({tag, ".data"}, {24'h0, b1.OutData}, {24'h0, d});
        chk({tag, ".valid"}, {31'h0, b1.OutValid}, {31'h0, v});
        chk({tag, ".done"}, {31'h0, b1.PatternDone}, {31'h0, p});
    endtask

    function automatic logic [7:0] pat(input int i);
        logic [31:0] w;
        w = 32'haabbccdd;
        return w[8*(i%4) +: 8];
    endfunction

    function automatic logic [7:0] mbyte(input int m);
        logic [7:0] b;
        for (int k = 0; k < 8; k++)
            b[k] = seq[15 + 8*m + k];
        return b;
    endfunction

    initial begin
        logic [14:0] s2;
        s2 = 15'h0001;
        for (int i = 0; i < 15; i++) seq[i] = s2[14-i];
        for (int n = 0; n + 15 < 8048; n++)
            seq[n+15] = seq[n] ^ seq[n+1];

        b1.Start = 0; b1.Stop = 0; b1.Enable = 1;
        b2.Start = 0; b2.Stop = 0; b2.Enable = 1;

        RST = 1;
        tick(); tick();
        out1("reset", 8'h00, 0, 0);
        chk("reset2.valid", {31'h0, b2.OutValid}, 0);
        RST = 0;

        // Full preamble then first PRBS bytes
        b1.Start = 1; tick(); b1.Start = 0;
        out1("start_lat", 8'h00, 0, 0);
        for (int i = 0; i < 16; i++) begin
            tick(); out1($sformatf("pre%0d", i), pat(i), 1, 0);
        end
        tick(); out1("prbs0", 8'h00, 1, 1);
        tick(); out1("prbs1", 8'h40, 1, 1);

        b1.Stop = 1; tick(); b1.Stop = 0;
        out1("stop", 8'h00, 0, 0);

        // Enable stall on byte 0xbb
        b1.Start = 1; tick(); b1.Start = 0;
        for (int i = 0; i < 3; i++) begin
            tick(); out1($sformatf("en_pre%0d", i), pat(i), 1, 0);
        end
        b1.Enable = 0;
        for (int i = 0; i < 3; i++) begin
            tick(); out1($sformatf("en_hold%0d", i), 8'hbb, 1, 0);
        end
        b1.Enable = 1;
        for (int i = 3; i < 16; i++) begin
            tick(); out1($sformatf("en_pre%0d", i), pat(i), 1, 0);
        end
        tick(); out1("en_prbs0", 8'h00, 1, 1);

        // Start and Stop together in IDLE
        b1.Stop = 1; tick();
        b1.Start = 1; tick();
        out1("ss_idle", 8'h00, 0, 0);
        b1.Stop = 0; tick(); b1.Start = 0;
        out1("ss_lat", 8'h00, 0, 0);
        tick(); out1("ss_first", 8'hdd, 1, 0);
        for (int i = 1; i < 16; i++) begin
            tick(); out1($sformatf("ss_pre%0d", i), pat(i), 1, 0);
        end
        tick(); out1("ss_prbs0", 8'h00, 1, 1);
        tick(); out1("ss_prbs1", 8'h40, 1, 1);

        // Stop while disabled, restart, Start in PAT
        b1.Enable = 0; b1.Stop = 1; tick();
        out1("stop_dis", 8'h00, 0, 0);
        b1.Stop = 0; b1.Enable = 1;
        b1.Start = 1; tick(); b1.Start = 0;
        out1("rs_lat", 8'h00, 0, 0);
        for (int i = 0; i < 16; i++) begin
            if (i == 5) b1.Start = 1;
            tick(); b1.Start = 0;
            out1($sformatf("rs_pre%0d", i), pat(i), 1, 0);
        end
        tick(); out1("rs_prbs0", 8'h00, 1, 1);
        tick(); out1("rs_prbs1", 8'h40, 1, 1);

        // Reset in repetition 2
        b1.Stop = 1; tick(); b1.Stop = 0;
        b1.Start = 1; tick(); b1.Start = 0;
        for (int i = 0; i < 9; i++) begin
            tick(); out1($sformatf("r_pre%0d", i), pat(i), 1, 0);
        end
        RST = 1; b1.Start = 1;
        tick(); out1("rst_mid", 8'h00, 0, 0);
        tick(); out1("rst_hold", 8'h00, 0, 0);
        RST = 0; b1.Start = 0;
        tick(); out1("rst_idle", 8'h00, 0, 0);
        b1.Start = 1; tick(); b1.Start = 0;
        out1("rst_lat", 8'h00, 0, 0);
        tick(); out1("rst_first", 8'hdd, 1, 0);
        b1.Stop = 1;

        // nPattern=1, Seed=1 against sequence model
        b2.Start = 1; tick(); b2.Start = 0;
        chk("d2_lat", {31'h0, b2.OutValid}, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("d2_pre%0d", i),
                {23'h0, b2.PatternDone, b2.OutData},
                {23'h0, 1'b0, pat(i)});
        end
        for (int m = 0; m < 1000; m++) begin
            tick();
            chk($sformatf("d2_prbs%0d", m),
                {22'h0, b2.OutValid, b2.PatternDone, b2.OutData},
                {22'h0, 2'b11, mbyte(m)});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
